// File: rtl/intr_request_ctrl_pkg.sv
// Shared definitions for the interrupt requester: source count, select width,
// FSM state encoding and the one-hot decode used to clear an acknowledged source.
package intr_request_ctrl_pkg;

   localparam int NUM_SRC = 4;
   localparam int SEL_W   = 2;

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_REQ     = 2'd1;
   localparam logic [1:0] ST_ACKED   = 2'd2;
   localparam logic [1:0] ST_SERVICE = 2'd3;

   function automatic logic [NUM_SRC-1:0] onehot(input logic [SEL_W-1:0] sel);
      onehot      = '0;
      onehot[sel] = 1'b1;
   endfunction

endpackage

// File: rtl/intr_prio_enc.sv
// Combinational fixed-priority encoder: index 3 wins, index 0 loses.
module intr_prio_enc
   import intr_request_ctrl_pkg::*;
(
   input  logic [NUM_SRC-1:0] req,
   output logic [SEL_W-1:0]   idx,
   output logic               valid
);

   // NOTE: every output of an always_comb gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      idx = '0;
      if (req[3])      idx = 2'd3;
      else if (req[2]) idx = 2'd2;
      else if (req[1]) idx = 2'd1;
      else             idx = 2'd0;
   end

   assign valid = |req;

endmodule

// File: rtl/intr_request_ctrl.sv
// Requester side of the IRQ/IACK handshake: edge-captures sources, arbitrates by
// fixed priority, raises IRQ, and tracks the acknowledged source in service until EOI.
module intr_request_ctrl
   import intr_request_ctrl_pkg::*;
#(
   parameter int ACK_TIMEOUT = 15
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NUM_SRC-1:0] src_irq,
   input  logic [NUM_SRC-1:0] irq_mask,
   input  logic               eoi,
   input  logic               IACK,
   output logic               IRQ,
   output logic [SEL_W-1:0]   priority_select,
   output logic [NUM_SRC-1:0] pending,
   output logic [NUM_SRC-1:0] in_service,
   output logic               timeout_err
);

   localparam logic [3:0] TO_LAST = 4'(ACK_TIMEOUT - 1);

   logic [1:0]         state;
   logic [3:0]         cnt;
   logic [NUM_SRC-1:0] src_q;
   logic [NUM_SRC-1:0] rise;
   logic [NUM_SRC-1:0] ack_clear;
   logic [NUM_SRC-1:0] eligible;
   logic [SEL_W-1:0]   winner;
   logic               winner_valid;

   assign rise      = src_irq & ~src_q;
   assign eligible  = pending & ~irq_mask;
   assign ack_clear = (state == ST_REQ && IACK) ? onehot(priority_select) : '0;

   intr_prio_enc u_prio_enc (
      .req   (eligible),
      .idx   (winner),
      .valid (winner_valid)
   );

   // A new edge on the bit being acknowledged must survive, so set is applied after clear.
   // NOTE: registers are updated with non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         src_q   <= '0;
         pending <= '0;
      end else begin
         src_q   <= src_irq;
         pending <= (pending & ~ack_clear) | rise;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state           <= ST_IDLE;
         IRQ             <= 1'b0;
         priority_select <= '0;
         cnt             <= '0;
         in_service      <= '0;
         timeout_err     <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (winner_valid && in_service == '0) begin
                  priority_select <= winner;
                  IRQ             <= 1'b1;
                  cnt             <= '0;
                  state           <= ST_REQ;
               end
            end
            ST_REQ: begin
               if (cnt != 4'hF) cnt <= cnt + 4'd1;
               if (IACK) begin
                  IRQ        <= 1'b0;
                  in_service <= onehot(priority_select);
                  state      <= ST_ACKED;
               end else if (irq_mask[priority_select]) begin
                  IRQ   <= 1'b0;
                  state <= ST_IDLE;
               end else if (cnt == TO_LAST) begin
                  // Pending bit is left set so the source is retried from IDLE.
                  IRQ         <= 1'b0;
                  timeout_err <= 1'b1;
                  state       <= ST_IDLE;
               end
            end
            ST_ACKED: begin
               if (eoi) begin
                  in_service <= '0;
                  state      <= ST_IDLE;
               end else if (!IACK) begin
                  state <= ST_SERVICE;
               end
            end
            ST_SERVICE: begin
               if (eoi) begin
                  in_service <= '0;
                  state      <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_intr_request_ctrl.sv
// Directed self-checking bench for intr_request_ctrl; expected values are hand-derived.
module tb_intr_request_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] src_irq;
   logic [3:0] irq_mask;
   logic       eoi;
   logic       IACK;
   logic       IRQ;
   logic [1:0] priority_select;
   logic [3:0] pending;
   logic [3:0] in_service;
   logic       timeout_err;

   int total  = 0;
   int passed = 0;

   intr_request_ctrl #(.ACK_TIMEOUT(15)) dut (
      .clk             (clk),
      .rst             (rst),
      .src_irq         (src_irq),
      .irq_mask        (irq_mask),
      .eoi             (eoi),
      .IACK            (IACK),
      .IRQ             (IRQ),
      .priority_select (priority_select),
      .pending         (pending),
      .in_service      (in_service),
      .timeout_err     (timeout_err)
   );

   always #5 clk = ~clk;

   // Inputs change and outputs are sampled 1 time unit after each rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      src_irq  = '0;
      irq_mask = '0;
      eoi      = 1'b0;
      IACK     = 1'b0;
      rst      = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      tick();
   endtask

   task automatic test_reset();
      do_reset();
      total++; if (IRQ !== 1'b0) $display("FAIL rst_irq: got %b want 0", IRQ); else passed++;
      total++; if (priority_select !== 2'd0) $display("FAIL rst_sel: got %0d want 0", priority_select); else passed++;
      total++; if (pending !== 4'b0000) $display("FAIL rst_pending: got %b want 0000", pending); else passed++;
      total++; if (in_service !== 4'b0000) $display("FAIL rst_in_service: got %b want 0000", in_service); else passed++;
      total++; if (timeout_err !== 1'b0) $display("FAIL rst_timeout: got %b want 0", timeout_err); else passed++;
   endtask

   task automatic test_basic_handshake();
      do_reset();
      src_irq = 4'b0100; tick();
      total++; if (pending !== 4'b0100) $display("FAIL t1_pending_latency: got %b want 0100", pending); else passed++;
      total++; if (IRQ !== 1'b0) $display("FAIL t1_irq_early: got %b want 0", IRQ); else passed++;
      src_irq = 4'b0000; tick();
      total++; if (IRQ !== 1'b1) $display("FAIL t1_irq: got %b want 1", IRQ); else passed++;
      total++; if (priority_select !== 2'd2) $display("FAIL t1_sel: got %0d want 2", priority_select); else passed++;
      eoi = 1'b1; tick(); eoi = 1'b0;
      total++; if (IRQ !== 1'b1) $display("FAIL t1_eoi_in_req_ignored: got %b want 1", IRQ); else passed++;
      IACK = 1'b1; tick();
      total++; if (IRQ !== 1'b0) $display("FAIL t1_irq_after_ack: got %b want 0", IRQ); else passed++;
      total++; if (pending !== 4'b0000) $display("FAIL t1_pending_cleared: got %b want 0000", pending); else passed++;
      total++; if (in_service !== 4'b0100) $display("FAIL t1_in_service: got %b want 0100", in_service); else passed++;
      IACK = 1'b0; tick();
      eoi = 1'b1; tick(); eoi = 1'b0;
      total++; if (in_service !== 4'b0000) $display("FAIL t1_eoi: got %b want 0000", in_service); else passed++;
   endtask

   task automatic test_priority();
      do_reset();
      src_irq = 4'b1001; tick();
      src_irq = 4'b0000; tick();
      total++; if (IRQ !== 1'b1 || priority_select !== 2'd3)
         $display("FAIL t2_first_sel: got irq=%b sel=%0d want irq=1 sel=3", IRQ, priority_select); else passed++;
      IACK = 1'b1; tick();
      total++; if (pending !== 4'b0001 || in_service !== 4'b1000)
         $display("FAIL t2_ack: got pend=%b insvc=%b want 0001/1000", pending, in_service); else passed++;
      IACK = 1'b0; tick();
      tick();
      total++; if (IRQ !== 1'b0) $display("FAIL t2_no_nesting: got %b want 0", IRQ); else passed++;
      eoi = 1'b1; tick(); eoi = 1'b0;
      total++; if (IRQ !== 1'b0 || in_service !== 4'b0000)
         $display("FAIL t2_eoi: got irq=%b insvc=%b want 0/0000", IRQ, in_service); else passed++;
      tick();
      total++; if (IRQ !== 1'b1 || priority_select !== 2'd0)
         $display("FAIL t2_second_sel: got irq=%b sel=%0d want irq=1 sel=0", IRQ, priority_select); else passed++;
   endtask

   task automatic test_timeout();
      int n;
      do_reset();
      src_irq = 4'b0010; tick();
      src_irq = 4'b0000; tick();
      n = 0;
      while (IRQ === 1'b1 && n < 40) begin
         n++;
         tick();
      end
      total++; if (n != 15) $display("FAIL t3_irq_cycles: got %0d want 15", n); else passed++;
      total++; if (timeout_err !== 1'b1) $display("FAIL t3_timeout_err: got %b want 1", timeout_err); else passed++;
      total++; if (pending !== 4'b0010) $display("FAIL t3_pending_kept: got %b want 0010", pending); else passed++;
      tick();
      total++; if (IRQ !== 1'b1 || priority_select !== 2'd1)
         $display("FAIL t3_retry: got irq=%b sel=%0d want irq=1 sel=1", IRQ, priority_select); else passed++;
      tick();
      total++; if (timeout_err !== 1'b1) $display("FAIL t3_sticky: got %b want 1", timeout_err); else passed++;
   endtask

   task automatic test_mask_and_no_preempt();
      do_reset();
      src_irq = 4'b0100; tick();
      src_irq = 4'b0000; tick();
      irq_mask = 4'b0100; tick();
      total++; if (IRQ !== 1'b0 || pending !== 4'b0100 || timeout_err !== 1'b0)
         $display("FAIL t4_masked_abort: got irq=%b pend=%b err=%b want 0/0100/0", IRQ, pending, timeout_err); else passed++;
      tick();
      total++; if (IRQ !== 1'b0) $display("FAIL t4_masked_idle: got %b want 0", IRQ); else passed++;
      irq_mask = 4'b0000; tick();
      total++; if (IRQ !== 1'b1 || priority_select !== 2'd2)
         $display("FAIL t4_unmask: got irq=%b sel=%0d want irq=1 sel=2", IRQ, priority_select); else passed++;
      src_irq = 4'b1000; tick();
      src_irq = 4'b0000; tick();
      total++; if (IRQ !== 1'b1 || priority_select !== 2'd2 || pending !== 4'b1100)
         $display("FAIL t4_no_preempt: got irq=%b sel=%0d pend=%b want 1/2/1100", IRQ, priority_select, pending); else passed++;
      IACK = 1'b1; tick();
      total++; if (in_service !== 4'b0100 || pending !== 4'b1000)
         $display("FAIL t4_ack: got insvc=%b pend=%b want 0100/1000", in_service, pending); else passed++;
      IACK = 1'b0;
   endtask

   task automatic test_back_to_back();
      do_reset();
      src_irq = 4'b0100; tick();
      src_irq = 4'b0000; tick();
      src_irq = 4'b0100; IACK = 1'b1; tick();
      total++; if (pending !== 4'b0100 || in_service !== 4'b0100 || IRQ !== 1'b0)
         $display("FAIL t5_set_wins: got pend=%b insvc=%b irq=%b want 0100/0100/0", pending, in_service, IRQ); else passed++;
      src_irq = 4'b0000; IACK = 1'b0; tick();
      eoi = 1'b1; tick(); eoi = 1'b0;
      tick();
      total++; if (IRQ !== 1'b1 || priority_select !== 2'd2)
         $display("FAIL t5_second_irq: got irq=%b sel=%0d want irq=1 sel=2", IRQ, priority_select); else passed++;
      IACK = 1'b1; tick();
      eoi = 1'b1; tick(); eoi = 1'b0;
      total++; if (in_service !== 4'b0000 || IRQ !== 1'b0)
         $display("FAIL t5_eoi_in_acked: got insvc=%b irq=%b want 0000/0", in_service, IRQ); else passed++;
      IACK = 1'b0; tick();
   endtask

   task automatic test_async_reset();
      do_reset();
      src_irq = 4'b0100; tick();
      src_irq = 4'b0000; tick();
      IACK = 1'b1; tick();
      IACK = 1'b0; tick();
      src_irq = 4'b0011; tick();
      src_irq = 4'b0000; tick();
      total++; if (pending !== 4'b0011 || in_service !== 4'b0100)
         $display("FAIL t6_setup: got pend=%b insvc=%b want 0011/0100", pending, in_service); else passed++;
      rst = 1'b1; #1;
      total++; if (IRQ !== 1'b0 || priority_select !== 2'd0 || pending !== 4'b0000 || in_service !== 4'b0000 || timeout_err !== 1'b0)
         $display("FAIL t6_async_clear: got irq=%b sel=%0d pend=%b insvc=%b err=%b want all 0",
                  IRQ, priority_select, pending, in_service, timeout_err); else passed++;
      tick();
      rst = 1'b0; tick();
      tick();
      total++; if (IRQ !== 1'b0) $display("FAIL t6_idle_after: got %b want 0", IRQ); else passed++;
      // Reset while IRQ is high must drop it without waiting for a clock edge.
      src_irq = 4'b1000; tick();
      src_irq = 4'b0000; tick();
      rst = 1'b1; #1;
      total++; if (IRQ !== 1'b0) $display("FAIL t6_irq_drop: got %b want 0", IRQ); else passed++;
      tick();
      rst = 1'b0; tick();
   endtask

   initial begin
      rst      = 1'b1;
      src_irq  = '0;
      irq_mask = '0;
      eoi      = 1'b0;
      IACK     = 1'b0;
      test_reset();
      test_basic_handshake();
      test_priority();
      test_timeout();
      test_mask_and_no_preempt();
      test_back_to_back();
      test_async_reset();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
